sampled_history_monitor: RTL and testbench
==========================================

SAMPLED_HISTORY_MONITOR -- requirements
Module: sampled_history_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent 1-bit channels.
REQ-002 SHALL have parameter DEPTH, default 2, legal range 1..16: history depth in enabled samples.
REQ-003 SHALL have parameter CNT_W, default 8: per-channel change-counter width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1: sample enable; only cycles with en=1 count as samples.
REQ-007 SHALL have port clr  input  1: synchronous clear of counters and saturation flags.
REQ-008 SHALL have port sig_in  input  WIDTH: monitored channels.
REQ-009 SHALL have port past_out  output  WIDTH: per-channel value sampled DEPTH samples earlier.
REQ-010 SHALL have port rose, fell, changed, stable  output  WIDTH each: per-channel registered event flags.
REQ-011 SHALL have port valid  output  1: history full; flags are meaningful.
REQ-012 SHALL have port chg_cnt  output  WIDTH*CNT_W: channel i count at bits [i*CNT_W +: CNT_W].
REQ-013 SHALL have port sat  output  WIDTH: sticky per-channel counter-saturated flag.

Function
REQ-014 SHALL keep a per-channel shift history hist[0..DEPTH-1]; on posedge with en=1, hist[0]<=sig_in, hist[j]<=hist[j-1].
REQ-015 SHALL hold all history, past_out, valid, counters and sat unchanged when en=0.
REQ-016 SHALL, on an enabled edge k, register past_out<=hist[DEPTH-1]: the sample taken DEPTH enabled edges before k (latency 1 cycle).
REQ-017 SHALL, on an enabled edge, register rose=sig_in&~hist[0], fell=~sig_in&hist[0], changed=sig_in^hist[0], stable=~(sig_in^hist[0]), each ANDed with fill-complete.
REQ-018 SHALL drive rose, fell, changed, stable to 0 on the edge following any cycle with en=0 (single-sample pulses, no hold).
REQ-019 SHALL count enabled samples in a fill counter saturating at DEPTH; valid SHALL assert on the enabled edge where the counter reaches DEPTH and stay high until reset.
REQ-020 SHALL gate all flags to 0 and inhibit counting while valid is 0 (fill-complete = counter already at DEPTH before the edge).
REQ-021 SHALL increment chg_cnt[i] by 1 on each enabled edge where changed[i] is computed as 1.
REQ-022 SHALL saturate chg_cnt[i] at 2^CNT_W-1 (no wrap); sat[i] SHALL set on the edge the count reaches max and remain set until clr or reset.
REQ-023 SHALL, with clr=1, set all chg_cnt and sat to 0 on that edge regardless of en; clr SHALL win over a simultaneous increment (result 0).
REQ-024 SHALL NOT let clr affect history, past_out, valid or the event flags.
REQ-025 SHALL treat channels fully independently; no cross-channel interaction.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force hist, past_out, rose, fell, changed, stable, valid, fill counter, chg_cnt and sat to 0.
REQ-027 SHALL, on reset asserted mid-operation, discard all history; after release, valid SHALL require DEPTH new enabled samples.

Verification
REQ-028 Fill: DEPTH=2, en=1, sig_in=4'b0001 constant from reset release -> valid=0 after edge 1, valid=1 after edge 2, stable=4'b1111 after edge 3.
REQ-029 Toggle: WIDTH=4, en=1, sig_in[0] toggles every edge after valid -> changed[0]=1 every cycle, rose/fell alternate, chg_cnt[0] +1 per edge, other channels 0.
REQ-030 Past: DEPTH=3, enabled sample sequence 1,0,0,1,1 on bit0 -> past_out[0] after edge 4 equals 1, after edge 5 equals 0.
REQ-031 Enable gap: en=0 for 3 cycles while sig_in changes, then en=1 -> flags 0 during gap, history unchanged, first enabled edge compares against pre-gap sample.
REQ-032 Saturation/clr: CNT_W=3, 9 changes on bit0 -> chg_cnt[0]=7, sat[0]=1; clr with simultaneous change -> chg_cnt[0]=0, sat[0]=0.
REQ-033 Async reset: drop rst_n between clock edges while valid=1 -> all outputs 0 immediately; after release, valid returns only after DEPTH enabled edges.

Source files
------------

// File: rtl/sampled_history_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : sampled_history_monitor_if
// Description : Sample/control inputs and per-channel result outputs of the
//               sampled history monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface sampled_history_monitor_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic                     en;
  logic                     clr;
  logic [WIDTH-1:0]         sig_in;
  logic [WIDTH-1:0]         past_out;
  logic [WIDTH-1:0]         rose;
  logic [WIDTH-1:0]         fell;
  logic [WIDTH-1:0]         changed;
  logic [WIDTH-1:0]         stable;
  logic                     valid;
  logic [WIDTH*CNT_W-1:0]   chg_cnt;
  logic [WIDTH-1:0]         sat;

  modport master (
    output en, clr, sig_in,
    input  past_out, rose, fell, changed, stable, valid, chg_cnt, sat
  );

  modport slave (
    input  en, clr, sig_in,
    output past_out, rose, fell, changed, stable, valid, chg_cnt, sat
  );
endinterface
`default_nettype wire

// File: rtl/sampled_history_monitor.sv
`default_nettype none
// ============================================================================
// Module      : sampled_history_monitor
// Description : Per-channel DEPTH-deep sample history with delayed output,
//               edge/change flags and saturating change counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sampled_history_monitor #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sampled_history_monitor_if.slave   bus
);

  localparam int c_FILL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    r_hist [DEPTH];
  logic [c_FILL_W-1:0] r_fill;
  logic                r_valid;
  logic [WIDTH-1:0]    r_past;
  logic [WIDTH-1:0]    r_rose;
  logic [WIDTH-1:0]    r_fell;
  logic [WIDTH-1:0]    r_changed;
  logic [WIDTH-1:0]    r_stable;

  logic                w_full;
  logic [c_FILL_W-1:0] w_fill_nxt;
  logic [WIDTH-1:0]    w_diff;
  logic [WIDTH-1:0]    w_gate;

  // Fill-complete is judged on the count before the edge, so the edge that
  // raises valid still produces zero flags.
  assign w_full     = (r_fill == c_FILL_W'(DEPTH));
  assign w_fill_nxt = w_full ? r_fill : r_fill + c_FILL_W'(1);
  assign w_diff     = bus.sig_in ^ r_hist[0];
  assign w_gate     = {WIDTH{w_full}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) r_hist[j] <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_past  <= '0;
    end else if (bus.en) begin
      r_hist[0] <= bus.sig_in;
      for (int j = 1; j < DEPTH; j++) r_hist[j] <= r_hist[j-1];
      r_past  <= r_hist[DEPTH-1];
      r_fill  <= w_fill_nxt;
      r_valid <= (w_fill_nxt == c_FILL_W'(DEPTH));
    end
  end

  // Flags are one-sample pulses: any disabled cycle clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rose    <= '0;
      r_fell    <= '0;
      r_changed <= '0;
      r_stable  <= '0;
    end else if (bus.en) begin
      r_rose    <= bus.sig_in & ~r_hist[0] & w_gate;
      r_fell    <= ~bus.sig_in & r_hist[0] & w_gate;
      r_changed <= w_diff & w_gate;
      r_stable  <= ~w_diff & w_gate;
    end else begin
      r_rose    <= '0;
      r_fell    <= '0;
      r_changed <= '0;
      r_stable  <= '0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_bump;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_bump    = bus.en & w_full & w_diff[i] & ~(&r_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (bus.clr) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_bump) begin
        r_cnt <= w_cnt_inc;
        r_sat <= r_sat | (&w_cnt_inc);
      end
    end

    assign bus.chg_cnt[i*CNT_W +: CNT_W] = r_cnt;
    assign bus.sat[i]                    = r_sat;
  end

  assign bus.past_out = r_past;
  assign bus.rose     = r_rose;
  assign bus.fell     = r_fell;
  assign bus.changed  = r_changed;
  assign bus.stable   = r_stable;
  assign bus.valid    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_sampled_history_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sampled_history_monitor
// Description : Randomized scoreboard bench with a queue-based history model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sampled_history_monitor;

  localparam int W   = 4;
  localparam int D   = 3;
  localparam int CW  = 3;
  localparam int MAX = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0]    past;
    logic [W-1:0]    rose;
    logic [W-1:0]    fell;
    logic [W-1:0]    changed;
    logic [W-1:0]    stable;
    logic [W-1:0]    sat;
    logic            valid;
    logic [W*CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sampled_history_monitor_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  sampled_history_monitor #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of enabled samples, newest at the back.
  logic [W-1:0] m_hist [$];
  int           m_n;
  int           m_cnt [W];
  logic [W-1:0] m_sat, m_past, m_rose, m_fell, m_chg, m_stab;
  logic         m_valid;
  exp_t         exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_n = 0;
    for (int i = 0; i < W; i++) m_cnt[i] = 0;
    m_sat = '0; m_past = '0; m_rose = '0; m_fell = '0;
    m_chg = '0; m_stab = '0; m_valid = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit c, input logic [W-1:0] s);
    logic [W-1:0] prev;
    bit           full;
    if (e) begin
      full = (m_n >= D);
      prev = (m_hist.size() > 0) ? m_hist[m_hist.size()-1] : '0;
      m_past = (m_hist.size() >= D) ? m_hist[m_hist.size()-D] : '0;
      m_rose = full ? (s & ~prev) : '0;
      m_fell = full ? (~s & prev) : '0;
      m_chg  = full ? (s ^ prev) : '0;
      m_stab = full ? ~(s ^ prev) : '0;
      if (full) begin
        for (int i = 0; i < W; i++) begin
          if (s[i] != prev[i] && m_cnt[i] < MAX) begin
            m_cnt[i]++;
            if (m_cnt[i] == MAX) m_sat[i] = 1'b1;
          end
        end
      end
      m_hist.push_back(s);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      if (m_n < D) m_n++;
      m_valid = (m_n >= D);
    end else begin
      m_rose = '0; m_fell = '0; m_chg = '0; m_stab = '0;
    end
    if (c) begin
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
      m_sat = '0;
    end
  endtask

  function automatic exp_t snap();
    exp_t x;
    x.past = m_past; x.rose = m_rose; x.fell = m_fell; x.changed = m_chg;
    x.stable = m_stab; x.sat = m_sat; x.valid = m_valid;
    for (int i = 0; i < W; i++) x.cnt[i*CW +: CW] = CW'(m_cnt[i]);
    return x;
  endfunction

  task automatic step(input bit e, input bit c, input logic [W-1:0] s);
    bus.en = e; bus.clr = c; bus.sig_in = s;
    @(posedge clk);
    #1;
    model_step(e, c, s);
    exp_q.push_back(snap());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_past"},    32'(bus.past_out), 0);
    chk({tag, "_flags"},   32'({bus.rose, bus.fell, bus.changed, bus.stable}), 0);
    chk({tag, "_valid"},   32'(bus.valid), 0);
    chk({tag, "_cnt"},     32'(bus.chg_cnt), 0);
    chk({tag, "_sat"},     32'(bus.sat), 0);
  endtask

  // Monitor: every posedge produces one expected entry, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("past_out", 32'(bus.past_out), 32'(e.past));
      chk("rose",     32'(bus.rose),     32'(e.rose));
      chk("fell",     32'(bus.fell),     32'(e.fell));
      chk("changed",  32'(bus.changed),  32'(e.changed));
      chk("stable",   32'(bus.stable),   32'(e.stable));
      chk("valid",    32'(bus.valid),    32'(e.valid));
      chk("chg_cnt",  32'(bus.chg_cnt),  32'(e.cnt));
      chk("sat",      32'(bus.sat),      32'(e.sat));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] s;
    total = 0; bad = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.clr = 1'b0; bus.sig_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("reset");
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Fill with a constant pattern, then toggle bit0 into saturation.
    for (int k = 0; k < D + 2; k++) step(1'b1, 1'b0, 4'b0001);
    s = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      s[0] = ~s[0];
      step(1'b1, 1'b0, s);
    end
    s[0] = ~s[0];
    step(1'b1, 1'b1, s);          // clear coincident with a change
    // Enable gap while the input moves, then resume.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, W'($urandom));
    step(1'b1, 1'b0, ~s);

    // Randomized traffic with occasional clears and gaps.
    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, W'($urandom));

    // Asynchronous reset between edges while valid is high.
    @(negedge clk); #2;
    chk("pre_reset_valid", 32'(bus.valid), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;

    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 4) != 0, $urandom_range(0, 39) == 0, W'($urandom));

    bus.en = 1'b0; bus.clr = 1'b0;
    @(negedge clk); #1;
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
